// File: rtl/cfeb_busy_sched_if.sv
// rtl/cfeb_busy_sched_if.sv - sorter winner / busy feedback bundle between the pattern sorter and busy scheduler
interface cfeb_busy_sched_if #(
  parameter int MXPATB  = 7,
  parameter int MXKEYBX = 8,
  parameter int MXCFEB  = 5
);
  logic [MXPATB-1:0]  best_pat_in;
  logic [MXKEYBX-1:0] best_key_in;
  logic               best_bsy_in;
  logic [MXCFEB-1:0]  bsy;

  modport master (
    output best_pat_in,
    output best_key_in,
    output best_bsy_in,
    input  bsy
  );

  modport slave (
    input  best_pat_in,
    input  best_key_in,
    input  best_bsy_in,
    output bsy
  );
endinterface

// File: rtl/cfeb_busy_sched.sv
// rtl/cfeb_busy_sched.sv - registers CFEB sorter winners as CLCTs and holds the winning CFEB busy for a drift window
module cfeb_busy_sched #(
  parameter int MXPATB    = 7,
  parameter int MXKEYBX   = 8,
  parameter int MXCFEB    = 5,
  parameter int MXDRIFT   = 4,
  parameter int MXTRIGCNT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [MXCFEB-1:0]    cfeb_en,
  input  logic [MXDRIFT-1:0]   drift_delay,
  input  logic [2:0]           hit_thresh,
  input  logic                 cnt_clear,
  cfeb_busy_sched_if.slave     sif,
  output logic                 clct_vld,
  output logic [MXPATB-1:0]    clct_pat,
  output logic [MXKEYBX-1:0]   clct_key,
  output logic                 all_busy,
  output logic                 key_err,
  output logic [MXTRIGCNT-1:0] trig_cnt
);
  localparam logic [2:0] LAST_CFEB = 3'(MXCFEB - 1);

  logic [2:0]          cfeb_id;
  logic [4:0]          strip;
  logic [2:0]          hits;
  logic                trig;
  logic                bad_key;
  logic [MXCFEB-1:0]   load;
  logic [MXCFEB-1:0]   bsy_w;
  logic [MXDRIFT-1:0]  dcnt [MXCFEB];

  assign cfeb_id = sif.best_key_in[MXKEYBX-1:MXKEYBX-3];
  assign strip   = sif.best_key_in[MXKEYBX-4:0];
  assign hits    = sif.best_pat_in[MXPATB-1:MXPATB-3];
  assign bad_key = !sif.best_bsy_in && (cfeb_id > LAST_CFEB);
  assign trig    = !sif.best_bsy_in && (hits >= hit_thresh) && (cfeb_id <= LAST_CFEB);

  // A key on the first/last two half-strips also blocks the neighbour that shares the track.
  always_comb begin
    load = '0;
    for (int i = 0; i < MXCFEB; i++) begin
      load[i] = trig && ((cfeb_id == 3'(i)) ||
                         ((strip <= 5'd1)  && (cfeb_id == 3'(i + 1))) ||
                         ((strip >= 5'd30) && (cfeb_id + 3'd1 == 3'(i))));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MXCFEB; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < MXCFEB; i++) begin
        if (load[i])
          dcnt[i] <= drift_delay;
        else if (dcnt[i] != '0)
          dcnt[i] <= dcnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clct_vld <= 1'b0;
      clct_pat <= '0;
      clct_key <= '0;
    end else begin
      clct_vld <= trig;
      clct_pat <= trig ? sif.best_pat_in : '0;
      clct_key <= trig ? sif.best_key_in : '0;
    end
  end

  // The count advances on the same edge that raises clct_vld, so a clear in the trigger cycle wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_cnt <= '0;
      key_err  <= 1'b0;
    end else if (cnt_clear) begin
      trig_cnt <= '0;
      key_err  <= 1'b0;
    end else begin
      if (trig && !(&trig_cnt)) trig_cnt <= trig_cnt + 1'b1;
      if (bad_key) key_err <= 1'b1;
    end
  end

  always_comb begin
    bsy_w = '0;
    for (int i = 0; i < MXCFEB; i++) bsy_w[i] = (dcnt[i] != '0) | ~cfeb_en[i];
  end

  assign sif.bsy  = bsy_w;
  assign all_busy = &bsy_w;
endmodule

// File: tb/tb_cfeb_busy_sched.sv
// tb/tb_cfeb_busy_sched.sv - scoreboard bench for cfeb_busy_sched with a timestamp-based busy model
module tb_cfeb_busy_sched;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  cfeb_en = 5'h1f;
  logic [3:0]  drift_delay = 4'd0;
  logic [2:0]  hit_thresh = 3'd0;
  logic        cnt_clear = 1'b0;
  logic        clct_vld;
  logic [6:0]  clct_pat;
  logic [7:0]  clct_key;
  logic        all_busy;
  logic        key_err;
  logic [15:0] trig_cnt;

  always #5 clock = ~clock;

  cfeb_busy_sched_if sif ();

  cfeb_busy_sched dut (
    .clock       (clock),
    .reset       (reset),
    .cfeb_en     (cfeb_en),
    .drift_delay (drift_delay),
    .hit_thresh  (hit_thresh),
    .cnt_clear   (cnt_clear),
    .sif         (sif.slave),
    .clct_vld    (clct_vld),
    .clct_pat    (clct_pat),
    .clct_key    (clct_key),
    .all_busy    (all_busy),
    .key_err     (key_err),
    .trig_cnt    (trig_cnt)
  );

  typedef struct packed {
    logic [4:0]  bsy;
    logic        ab;
    logic        vld;
    logic        kerr;
    logic [15:0] cnt;
  } stat_t;

  typedef struct packed {
    logic [6:0] pat;
    logic [7:0] key;
  } trig_t;

  stat_t exp_q[$];
  trig_t trig_q[$];
  int    total = 0;
  int    bad = 0;

  // Model: a CFEB is busy in every cycle up to and including busy_until (trigger cycle + D).
  int busy_until[5];
  int cyc = 0;
  bit prev_trig = 0;
  int cnt = 0;
  bit kerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic stat_t model_status(input logic [4:0] en);
    stat_t e;
    for (int i = 0; i < 5; i++) e.bsy[i] = (busy_until[i] >= cyc) || !en[i];
    e.ab   = &e.bsy;
    e.vld  = prev_trig;
    e.kerr = kerr;
    e.cnt  = 16'(cnt);
    return e;
  endfunction

  task automatic step(input logic [4:0] en, input logic [3:0] d, input logic [2:0] th,
                      input logic [6:0] pat, input logic [7:0] key, input logic bi, input logic clr);
    int c;
    int s;
    bit t;
    bit ke;
    @(posedge clock);
    #1;
    reset           = 1'b0;
    cfeb_en         = en;
    drift_delay     = d;
    hit_thresh      = th;
    cnt_clear       = clr;
    sif.best_pat_in = pat;
    sif.best_key_in = key;
    sif.best_bsy_in = bi;
    exp_q.push_back(model_status(en));
    c  = int'(key[7:5]);
    s  = int'(key[4:0]);
    ke = !bi && (c > 4);
    t  = !bi && (int'(pat[6:4]) >= int'(th)) && (c <= 4);
    if (clr) begin
      cnt  = 0;
      kerr = 0;
    end else begin
      if (t && cnt < 65535) cnt++;
      if (ke) kerr = 1;
    end
    if (t) begin
      busy_until[c] = cyc + int'(d);
      if (s <= 1 && c > 0)  busy_until[c-1] = cyc + int'(d);
      if (s >= 30 && c < 4) busy_until[c+1] = cyc + int'(d);
      trig_q.push_back({pat, key});
    end
    prev_trig = t;
    cyc++;
  endtask

  task automatic idle(input logic [4:0] en);
    step(en, 4'd0, 3'd0, 7'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input logic [4:0] en);
    stat_t e;
    @(posedge clock);
    #1;
    reset           = 1'b1;
    cfeb_en         = en;
    cnt_clear       = 1'b0;
    sif.best_bsy_in = 1'b1;
    e.bsy  = ~en;
    e.ab   = &(~en);
    e.vld  = 1'b0;
    e.kerr = 1'b0;
    e.cnt  = 16'h0;
    exp_q.push_back(e);
    for (int i = 0; i < 5; i++) busy_until[i] = -1;
    prev_trig = 0;
    cnt       = 0;
    kerr      = 0;
    trig_q.delete();
    cyc++;
  endtask

  always @(negedge clock) begin
    stat_t e;
    trig_t tr;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("bsy",      32'(sif.bsy),  32'(e.bsy));
      check("all_busy", 32'(all_busy), 32'(e.ab));
      check("clct_vld", 32'(clct_vld), 32'(e.vld));
      check("key_err",  32'(key_err),  32'(e.kerr));
      check("trig_cnt", 32'(trig_cnt), 32'(e.cnt));
    end
    if (clct_vld === 1'b1) begin
      if (trig_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL clct_unexpected actual=1 required=0");
      end else begin
        tr = trig_q.pop_front();
        check("clct_pat", 32'(clct_pat), 32'(tr.pat));
        check("clct_key", 32'(clct_key), 32'(tr.key));
      end
    end
  end

  initial begin
    sif.best_pat_in = '0;
    sif.best_key_in = '0;
    sif.best_bsy_in = 1'b1;
    for (int i = 0; i < 5; i++) busy_until[i] = -1;

    do_reset(5'h1f);
    do_reset(5'h1f);

    step(5'h1f, 4'd3, 3'd4, 7'h5a, 8'h45, 1'b0, 1'b0);
    repeat (4) idle(5'h1f);

    step(5'h1f, 4'd2, 3'd0, 7'h40, 8'h3f, 1'b0, 1'b0);
    repeat (3) idle(5'h1f);
    step(5'h1f, 4'd2, 3'd0, 7'h40, 8'h00, 1'b0, 1'b0);
    repeat (3) idle(5'h1f);

    step(5'h1f, 4'd3, 3'd4, 7'h3a, 8'h45, 1'b0, 1'b0);
    step(5'h1f, 4'd3, 3'd0, 7'h7f, 8'h45, 1'b1, 1'b0);
    step(5'h1f, 4'd3, 3'd0, 7'h7f, 8'ha0, 1'b0, 1'b0);
    repeat (2) idle(5'h1f);

    repeat (5) step(5'h1f, 4'd0, 3'd2, 7'h60, 8'h65, 1'b0, 1'b0);
    idle(5'h1f);

    step(5'h1f, 4'd8, 3'd1, 7'h50, 8'h4a, 1'b0, 1'b0);
    repeat (2) idle(5'h1f);
    do_reset(5'h1f);
    idle(5'h1f);

    step(5'h1f, 4'd6, 3'd0, 7'h10, 8'h40, 1'b0, 1'b0);
    step(5'h1f, 4'd2, 3'd0, 7'h10, 8'h5f, 1'b0, 1'b0);
    step(5'h17, 4'd2, 3'd0, 7'h10, 8'h88, 1'b1, 1'b0);
    repeat (8) idle(5'h1f);

    for (int n = 0; n < 2000; n++) begin
      logic [4:0] en;
      en = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'h1f;
      step(en, 4'($urandom_range(0, 5)), 3'($urandom), 7'($urandom), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0));
    end
    repeat (6) idle(5'h1f);

    step(5'h1f, 4'd0, 3'd0, 7'h00, 8'ha0, 1'b0, 1'b1);
    step(5'h1f, 4'd0, 3'd0, 7'h00, 8'ha0, 1'b0, 1'b0);
    for (int n = 0; n < 65536; n++) step(5'h1f, 4'd0, 3'd0, 7'h22, 8'h65, 1'b0, 1'b0);
    idle(5'h1f);
    step(5'h1f, 4'd0, 3'd0, 7'h22, 8'h65, 1'b0, 1'b1);
    idle(5'h1f);

    step(5'h0f, 4'd8, 3'd0, 7'h70, 8'h00, 1'b0, 1'b0);
    step(5'h0f, 4'd8, 3'd0, 7'h70, 8'h3f, 1'b0, 1'b0);
    step(5'h0f, 4'd8, 3'd0, 7'h70, 8'h60, 1'b0, 1'b0);
    repeat (10) idle(5'h0f);
    repeat (2) idle(5'h1f);

    @(negedge clock);
    #1;
    check("trig_q_drain", 32'(trig_q.size()), 32'd0);
    check("exp_q_drain",  32'(exp_q.size()),  32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
